axi_lite_regfile: RTL and testbench
===================================

AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 SHALL have parameter N_REGS, default 16, meaning number of 32-bit registers (1..64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning AXI byte-address width, which SHALL be >= clog2(N_REGS)+2.
REQ-003 SHALL have parameter RO_MASK, default all zeros (N_REGS bits), meaning that bit i=1 makes register i read-only and sourced from reg_in.
REQ-004 SHALL have parameter W1C_MASK, default all zeros (N_REGS bits), meaning that bit i=1 makes register i write-1-to-clear (see REQ-024).
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 Ports (name, direction, width, meaning):
- aclk in 1: clock.
- areset in 1: asynchronous active-high reset.
- awaddr in ADDR_WIDTH, awprot in 3 (ignored), awvalid in 1, awready out 1: AXI-Lite write address channel.
- wdata in 32, wstrb in 4, wvalid in 1, wready out 1: write data channel.
- bresp out 2, bvalid out 1, bready in 1: write response channel.
- araddr in ADDR_WIDTH, arprot in 3 (ignored), arvalid in 1, arready out 1: read address channel.
- rdata out 32, rresp out 2, rvalid out 1, rready in 1: read data channel.
- reg_out out N_REGS*32: current register contents; register i occupies bits [32i+31:32i].
- reg_in in N_REGS*32: hardware values for RO registers.
- reg_set in N_REGS*32: hardware set bits for W1C registers.
- wr_pulse out N_REGS: one-cycle strobe per committed write.
- rd_pulse out N_REGS: one-cycle strobe per completed read.

Function
REQ-007 Register index SHALL be addr[ADDR_WIDTH-1:2]; addr[1:0] SHALL be ignored.
REQ-008 AW and W SHALL be accepted independently, in any order or in the same cycle, each into its own holding register.
REQ-009 awready SHALL be 1 iff no address is held and bvalid=0; wready SHALL be 1 iff no data is held and bvalid=0.
REQ-010 Commit SHALL occur on the first edge at which both address and data are held or being accepted.
- At commit: register update, bvalid<=1, bresp set, holding registers cleared.
REQ-011 bvalid SHALL stay high until the bready handshake; no new AW or W SHALL be accepted meanwhile.
REQ-012 A write to a valid RW register SHALL update only bytes whose wstrb bit is 1, with bresp=2'b00.
REQ-013 A write with index>=N_REGS or to an RO register SHALL change no state and SHALL give bresp=2'b10 (SLVERR).
REQ-014 wr_pulse[i] SHALL be high exactly for the cycle after a successful commit to register i, coincident with bvalid rising.
REQ-015 arready SHALL be 1 iff rvalid=0; an accepted read SHALL assert rvalid on the next edge (1-cycle latency).
REQ-016 rdata SHALL be reg_in[i] for RO registers (sampled at acceptance), otherwise the stored value.
REQ-017 For index>=N_REGS: rdata=0 and rresp=2'b10; otherwise rresp=2'b00.
REQ-018 rdata and rresp SHALL be held stable while rvalid=1 and rready=0.
REQ-019 rd_pulse[i] SHALL be high for one cycle coincident with rvalid rising for a valid index i.
REQ-020 A read and a commit to the same register on the same edge SHALL return the pre-write value.
REQ-021 reg_out for RO registers SHALL mirror reg_in combinationally.

Reset
REQ-022 While areset=1, all outputs, stored registers, holding registers and pulses SHALL be 0, including all ready signals.
REQ-023 Assertion of areset mid-transaction SHALL discard pending AW/W/AR with no response.
- Ready signals SHALL rise on the first edge after deassertion.

Configuration
REQ-024 With AXI_LITE_REGFILE_W1C_EN defined, W1C_MASK registers SHALL behave as follows:
- A write clears the bits set in wdata within strobed bytes.
- A bit SHALL be set while its reg_set bit is 1.
- Set SHALL win over a same-cycle clear.
REQ-025 Without AXI_LITE_REGFILE_W1C_EN, W1C_MASK and reg_set SHALL be ignored and those registers SHALL be plain RW.

Verification
REQ-026 Write-order scenarios:
- AW(0x04) in cycle 1, W(0xDEADBEEF, strb 0xF) in cycle 3 -> bvalid in cycle 4, bresp=00, reg 1=0xDEADBEEF, wr_pulse[1] for one cycle.
- W before AW, and AW+W in the same cycle -> identical result.
REQ-027 Reg 2=0x11223344, write 0xAABBCCDD with strb 0x5 -> reg 2=0x11BB33DD.
REQ-028 Read 0x40 with N_REGS=16 -> rresp=10, rdata=0; write 0x40 -> bresp=10, no reg_out change; RO write -> bresp=10.
REQ-029 Hold rready=0 for 5 cycles after a read of 0x08 -> rdata stable; arready=0 until the handshake; rd_pulse[2] for one cycle only.
REQ-030 W1C (macro defined): reg 3=0xF0, write 0x30 -> 0xC0; same-cycle reg_set bit 4 -> result 0xD0.
REQ-031 Assert areset between AW and W acceptance -> no bvalid, all outputs 0; a subsequent write completes normally.

Source files
------------

// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite bus bundle for axi_lite_regfile.
// master: drives requests (bench / interconnect); slave: the register file.
interface axi_lite_regfile_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register file: N_REGS x 32-bit, RW / RO (from reg_in) registers,
// byte strobes, SLVERR on out-of-range or RO writes, per-register pulses.
// Optional write-1-to-clear registers: define AXI_LITE_REGFILE_W1C_EN.
//
// Write-side FSM:
//   state   | meaning
//   ST_RST  | first cycle after reset, all readies held low
//   ST_IDLE | nothing held, AW and W both acceptable
//   ST_ADDR | address held, waiting for data
//   ST_DATA | data held, waiting for address
//   ST_RESP | bvalid high, waiting for bready
module axi_lite_regfile #(
  parameter int                N_REGS     = 16,
  parameter int                ADDR_WIDTH = 8,
  parameter logic [N_REGS-1:0] RO_MASK    = '0,
  parameter logic [N_REGS-1:0] W1C_MASK   = '0
) (
  input  logic                   aclk,
  input  logic                   areset,
  axi_lite_regfile_if.slave      axi,
  output logic [N_REGS*32-1:0]   reg_out,
  input  logic [N_REGS*32-1:0]   reg_in,
  input  logic [N_REGS*32-1:0]   reg_set,
  output logic [N_REGS-1:0]      wr_pulse,
  output logic [N_REGS-1:0]      rd_pulse
);
  localparam int IDXW = ADDR_WIDTH - 2;

  typedef enum logic [2:0] {ST_RST, ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} wr_state_t;

  wr_state_t             state_q, state_d;
  logic                  aw_acc, w_acc, ar_acc, commit, c_ok;
  logic [IDXW-1:0]       aw_idx_q, w_idx, r_idx;
  logic [31:0]           wdata_q, c_wdata, c_bmask;
  logic [3:0]            wstrb_q, c_wstrb;
  logic [1:0]            bresp_q;
  logic [N_REGS-1:0]     wr_hit, r_hit;
  logic [N_REGS*32-1:0]  regs_flat;
  logic [31:0]           r_val, rdata_q;
  logic                  r_ok, rvalid_q;
  logic [1:0]            rresp_q;

  assign axi.awready = (state_q == ST_IDLE) || (state_q == ST_DATA);
  assign axi.wready  = (state_q == ST_IDLE) || (state_q == ST_ADDR);
  assign axi.bvalid  = (state_q == ST_RESP);
  assign axi.bresp   = bresp_q;
  assign axi.arready = (state_q != ST_RST) && !rvalid_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

  assign aw_acc = axi.awvalid && axi.awready;
  assign w_acc  = axi.wvalid && axi.wready;
  assign ar_acc = axi.arvalid && axi.arready;
  // Commit as soon as both halves are either held or arriving this cycle.
  assign commit = (aw_acc || state_q == ST_ADDR) && (w_acc || state_q == ST_DATA);

  assign w_idx   = (state_q == ST_ADDR) ? aw_idx_q : axi.awaddr[ADDR_WIDTH-1:2];
  assign c_wdata = (state_q == ST_DATA) ? wdata_q : axi.wdata;
  assign c_wstrb = (state_q == ST_DATA) ? wstrb_q : axi.wstrb;
  assign c_bmask = {{8{c_wstrb[3]}}, {8{c_wstrb[2]}}, {8{c_wstrb[1]}}, {8{c_wstrb[0]}}};
  assign r_idx   = axi.araddr[ADDR_WIDTH-1:2];

  // Write FSM state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= ST_RST;
    else        state_q <= state_d;
  end

  // Write FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:  state_d = ST_IDLE;
      ST_IDLE: begin
        if (commit)      state_d = ST_RESP;
        else if (aw_acc) state_d = ST_ADDR;
        else if (w_acc)  state_d = ST_DATA;
      end
      ST_ADDR: if (commit) state_d = ST_RESP;
      ST_DATA: if (commit) state_d = ST_RESP;
      ST_RESP: if (axi.bready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture whichever half of the write arrives first; cleared at commit.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (commit) begin
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (aw_acc) aw_idx_q <= axi.awaddr[ADDR_WIDTH-1:2];
      if (w_acc) begin
        wdata_q <= axi.wdata;
        wstrb_q <= axi.wstrb;
      end
    end
  end

  // Decode the committing write; RO and out-of-range indices hit nothing.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < N_REGS; i++)
      wr_hit[i] = commit && (int'(w_idx) == i) && !RO_MASK[i];
  end
  assign c_ok = |wr_hit;

  // Write response and per-register write strobe.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bresp_q  <= 2'b00;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= wr_hit;
      if (commit) bresp_q <= c_ok ? 2'b00 : 2'b10;
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_reg
    logic [31:0] q;

    // Register storage: strobed byte merge, or set/clear for W1C registers.
    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        q <= '0;
      end else begin
`ifdef AXI_LITE_REGFILE_W1C_EN
        if (W1C_MASK[g] && !RO_MASK[g])
          q <= (q & ~(wr_hit[g] ? (c_wdata & c_bmask) : 32'h0)) | reg_set[32*g +: 32];
        else
`endif
        if (wr_hit[g]) q <= (q & ~c_bmask) | (c_wdata & c_bmask);
      end
    end

    assign regs_flat[32*g +: 32] = q;
    assign reg_out[32*g +: 32]   = RO_MASK[g] ? (areset ? 32'h0 : reg_in[32*g +: 32]) : q;
  end

  // Read mux; sees the pre-write value when a commit lands on the same edge.
  always_comb begin
    r_val = 32'h0;
    r_ok  = 1'b0;
    r_hit = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (int'(r_idx) == i) begin
        r_ok     = 1'b1;
        r_hit[i] = 1'b1;
        r_val    = RO_MASK[i] ? reg_in[32*i +: 32] : regs_flat[32*i +: 32];
      end
    end
  end

  // Read channel: one-cycle latency, data held until rready.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
      rd_pulse <= '0;
    end else begin
      rd_pulse <= '0;
      if (ar_acc) begin
        rvalid_q <= 1'b1;
        rdata_q  <= r_val;
        rresp_q  <= r_ok ? 2'b00 : 2'b10;
        rd_pulse <= r_hit;
      end else if (rvalid_q && axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Protection bits, sub-word address bits and (when W1C is off) reg_set are don't-cares.
  logic unused_ok;
  assign unused_ok = ^{axi.awprot, axi.arprot, axi.awaddr[1:0], axi.araddr[1:0], reg_set};
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile with a small reference model and
// response scoreboards. Reg 5 is RO, reg 3 is in W1C_MASK.
module tb_axi_lite_regfile;
  localparam int          NR   = 16;
  localparam logic [15:0] RO_M = 16'h0020;
  localparam logic [15:0] W1_M = 16'h0008;

  typedef struct packed { logic [1:0] r; logic [15:0] p; } bexp_t;
  typedef struct packed { logic [31:0] d; logic [1:0] r; logic [15:0] p; } rexp_t;

  logic aclk = 1'b0;
  logic areset;
  logic [NR*32-1:0] reg_out, reg_in, reg_set;
  logic [NR-1:0] wr_pulse, rd_pulse;

  axi_lite_regfile_if #(.ADDR_WIDTH(8)) bus ();

  axi_lite_regfile #(.N_REGS(NR), .ADDR_WIDTH(8), .RO_MASK(RO_M), .W1C_MASK(W1_M)) dut (
    .aclk(aclk), .areset(areset), .axi(bus), .reg_out(reg_out), .reg_in(reg_in),
    .reg_set(reg_set), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse));

  always #5 aclk = ~aclk;

  int vec = 0;
  int errs = 0;
  logic [31:0] model [NR];
  bexp_t exp_b [$];
  rexp_t exp_r [$];

  task automatic chk(input string tag, input logic [NR*32-1:0] obs, input logic [NR*32-1:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  function automatic logic [NR*32-1:0] exp_regs();
    logic [NR*32-1:0] v;
    for (int i = 0; i < NR; i++) v[32*i +: 32] = RO_M[i] ? reg_in[32*i +: 32] : model[i];
    return v;
  endfunction

  function automatic bexp_t model_wr(input logic [7:0] a, input logic [31:0] d,
                                     input logic [3:0] s, input logic [31:0] set3);
    bexp_t e;
    int i;
    logic [31:0] m;
    i = int'(a[7:2]);
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    e.r = 2'b10;
    e.p = '0;
    if (i < NR && !RO_M[i]) begin
      e.r = 2'b00;
      e.p[i] = 1'b1;
`ifdef AXI_LITE_REGFILE_W1C_EN
      if (W1_M[i]) model[i] = (model[i] & ~(d & m)) | set3;
      else
`endif
      model[i] = (model[i] & ~m) | (d & m);
    end
    return e;
  endfunction

  // mode 0: AW, idle, W; mode 1: W, idle, AW; mode 2: both together.
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int mode, input logic [31:0] set3);
    bexp_t e;
    exp_b.push_back(model_wr(a, d, s, set3));
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    if (mode == 0) begin
      bus.awvalid = 1'b1; tick(); bus.awvalid = 1'b0;
      chk("awready_held", bus.awready, 0);
      chk("bvalid_early", bus.bvalid, 0);
      tick();
      bus.wvalid = 1'b1; tick(); bus.wvalid = 1'b0;
    end else if (mode == 1) begin
      bus.wvalid = 1'b1; tick(); bus.wvalid = 1'b0;
      chk("wready_held", bus.wready, 0);
      chk("bvalid_early", bus.bvalid, 0);
      tick();
      bus.awvalid = 1'b1; tick(); bus.awvalid = 1'b0;
    end else begin
      reg_set[3*32 +: 32] = set3;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      reg_set[3*32 +: 32] = 32'h0;
    end
    e = exp_b.pop_front();
    chk("bvalid", bus.bvalid, 1);
    chk("bresp", bus.bresp, e.r);
    chk("wr_pulse", wr_pulse, e.p);
    chk("awready_in_resp", bus.awready, 0);
    bus.bready = 1'b1; tick(); bus.bready = 1'b0;
    chk("wr_pulse_once", wr_pulse, 0);
    chk("bvalid_drop", bus.bvalid, 0);
    chk("reg_out", reg_out, exp_regs());
  endtask

  task automatic rd(input logic [7:0] a, input int hold);
    rexp_t e;
    int i;
    i = int'(a[7:2]);
    e.d = 32'h0; e.r = 2'b10; e.p = '0;
    if (i < NR) begin
      e.r = 2'b00;
      e.p[i] = 1'b1;
      e.d = RO_M[i] ? reg_in[32*i +: 32] : model[i];
    end
    exp_r.push_back(e);
    chk("arready_idle", bus.arready, 1);
    bus.araddr = a; bus.arvalid = 1'b1; tick(); bus.arvalid = 1'b0;
    e = exp_r.pop_front();
    chk("rvalid", bus.rvalid, 1);
    chk("rdata", bus.rdata, e.d);
    chk("rresp", bus.rresp, e.r);
    chk("rd_pulse", rd_pulse, e.p);
    for (int k = 0; k < hold; k++) begin
      reg_in[5*32 +: 32] = $urandom;
      tick();
      chk("rdata_hold", bus.rdata, e.d);
      chk("rresp_hold", bus.rresp, e.r);
      chk("arready_busy", bus.arready, 0);
      chk("rd_pulse_once", rd_pulse, 0);
    end
    bus.rready = 1'b1; tick(); bus.rready = 1'b0;
    chk("rvalid_drop", bus.rvalid, 0);
    chk("arready_back", bus.arready, 1);
  endtask

  initial begin
    bexp_t eb;
    rexp_t er;
    areset = 1'b1;
    bus.awaddr = '0; bus.awprot = 3'b010; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = 3'b001; bus.arvalid = 1'b0; bus.rready = 1'b0;
    reg_in = '0;
    reg_in[5*32 +: 32] = 32'h5A5A_0005;
    reg_set = '0;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;

    repeat (2) @(negedge aclk);
    chk("rst_awready", bus.awready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_reg_out", reg_out, 0);
    chk("rst_pulses", {wr_pulse, rd_pulse}, 0);
    areset = 1'b0;
    #1;
    chk("post_rst_awready_low", bus.awready, 0);
    tick();
    chk("post_rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    chk("ro_mirror", reg_out, exp_regs());

    // Write orderings, all ending with reg 1 = DEADBEEF.
    wr(8'h04, 32'hDEAD_BEEF, 4'hF, 0, 32'h0);
    chk("reg1_aw_first", reg_out[32 +: 32], 32'hDEAD_BEEF);
    wr(8'h04, 32'h0000_0000, 4'hF, 2, 32'h0);
    wr(8'h04, 32'hDEAD_BEEF, 4'hF, 1, 32'h0);
    chk("reg1_w_first", reg_out[32 +: 32], 32'hDEAD_BEEF);
    wr(8'h04, 32'h0000_0000, 4'hF, 0, 32'h0);
    wr(8'h04, 32'hDEAD_BEEF, 4'hF, 2, 32'h0);
    chk("reg1_same_cycle", reg_out[32 +: 32], 32'hDEAD_BEEF);

    // Byte strobes; low address bits ignored.
    wr(8'h08, 32'h1122_3344, 4'hF, 2, 32'h0);
    wr(8'h0B, 32'hAABB_CCDD, 4'h5, 0, 32'h0);
    chk("reg2_strobe", reg_out[64 +: 32], 32'h11BB_33DD);

    // Out-of-range and RO accesses.
    rd(8'h40, 0);
    wr(8'h40, 32'hFFFF_FFFF, 4'hF, 2, 32'h0);
    wr(8'h14, 32'h1234_5678, 4'hF, 1, 32'h0);
    rd(8'h14, 3);
    rd(8'h08, 5);
    rd(8'h06, 0);

    // Read and commit to the same register on the same edge.
    wr(8'h18, 32'h6666_0000, 4'hF, 2, 32'h0);
    er.d = model[6]; er.r = 2'b00; er.p = 16'h0040;
    exp_r.push_back(er);
    exp_b.push_back(model_wr(8'h18, 32'h7777_7777, 4'hF, 32'h0));
    bus.araddr = 8'h18; bus.awaddr = 8'h18; bus.wdata = 32'h7777_7777; bus.wstrb = 4'hF;
    bus.arvalid = 1'b1; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    er = exp_r.pop_front();
    eb = exp_b.pop_front();
    chk("same_edge_rdata", bus.rdata, er.d);
    chk("same_edge_rd_pulse", rd_pulse, er.p);
    chk("same_edge_bresp", {bus.bvalid, bus.bresp}, {1'b1, eb.r});
    chk("same_edge_wr_pulse", wr_pulse, eb.p);
    bus.rready = 1'b1; bus.bready = 1'b1; tick();
    bus.rready = 1'b0; bus.bready = 1'b0;
    chk("same_edge_reg6", reg_out[6*32 +: 32], 32'h7777_7777);

    // Register 3: W1C when the feature is built in, plain RW otherwise.
    reg_set[3*32 +: 32] = 32'h0000_00F0; tick(); reg_set[3*32 +: 32] = 32'h0;
`ifdef AXI_LITE_REGFILE_W1C_EN
    model[3] = model[3] | 32'h0000_00F0;
`endif
    chk("reg3_after_set", reg_out, exp_regs());
    wr(8'h0C, 32'h0000_0030, 4'hF, 0, 32'h0);
`ifdef AXI_LITE_REGFILE_W1C_EN
    chk("w1c_clear", reg_out[3*32 +: 32], 32'h0000_00C0);
`else
    chk("rw_reg3", reg_out[3*32 +: 32], 32'h0000_0030);
`endif
    reg_set[3*32 +: 32] = 32'h0000_00F0; tick(); reg_set[3*32 +: 32] = 32'h0;
`ifdef AXI_LITE_REGFILE_W1C_EN
    model[3] = model[3] | 32'h0000_00F0;
`endif
    wr(8'h0C, 32'h0000_0030, 4'hF, 2, 32'h0000_0010);
`ifdef AXI_LITE_REGFILE_W1C_EN
    chk("w1c_set_wins", reg_out[3*32 +: 32], 32'h0000_00D0);
`else
    chk("rw_reg3_set_ignored", reg_out[3*32 +: 32], 32'h0000_0030);
`endif

    // Reset between AW and W acceptance discards the write.
    bus.awaddr = 8'h24; bus.awvalid = 1'b1; tick(); bus.awvalid = 1'b0;
    areset = 1'b1;
    #1;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    chk("midrst_bvalid", bus.bvalid, 0);
    chk("midrst_ready", {bus.awready, bus.wready, bus.arready}, 0);
    chk("midrst_reg_out", reg_out, 0);
    chk("midrst_rvalid", bus.rvalid, 0);
    bus.wdata = 32'hBAD0_BAD0; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge aclk);
    bus.wvalid = 1'b0;
    areset = 1'b0;
    tick();
    chk("post_midrst_bvalid", bus.bvalid, 0);
    chk("post_midrst_regs", reg_out, exp_regs());
    wr(8'h04, 32'h1234_5678, 4'hF, 0, 32'h0);
    rd(8'h04, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
